// File: rtl/mem_arbiter_rr.sv
// Two-port round-robin arbiter and sequencer for a shared single-port word memory.
// Each granted request runs a fixed IDLE -> ACC -> RESP sequence ending in a done pulse.
module mem_arbiter_rr #(
    parameter int unsigned ADRS_WIDTH = 2,
    parameter int unsigned WORD_DEPTH = 4,
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADRS_WIDTH-1:0] adrs0,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADRS_WIDTH-1:0] adrs1,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  done0,
    output logic [WORD_WIDTH-1:0] rdata0,
    output logic                  err0,
    output logic                  gnt1,
    output logic                  done1,
    output logic [WORD_WIDTH-1:0] rdata1,
    output logic                  err1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADRS_WIDTH-1:0] mem_adrs,
    output logic [WORD_WIDTH-1:0] mem_din,
    input  logic [WORD_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  id_q, id_d;
    logic                  we_q, we_d;
    logic [ADRS_WIDTH-1:0] adrs_q, adrs_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [WORD_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WORD_WIDTH-1:0] rdata1_q, rdata1_d;

    logic legal;
    logic elig0, elig1;
    logic grant_id;

    assign legal = (32'(adrs_q) < WORD_DEPTH);

    // A port whose done pulse is still high is not re-granted in that cycle.
    assign elig0 = req0 & ~done_q[0];
    assign elig1 = req1 & ~done_q[1];

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        id_d     = id_q;
        we_d     = we_q;
        adrs_d   = adrs_q;
        wdata_d  = wdata_q;
        done_d   = 2'b00;
        err_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        grant_id = 1'b0;

        case (state_q)
            StIdle: begin
                if (elig0 || elig1) begin
                    grant_id = (elig0 && elig1) ? prio_q : elig1;
                    id_d     = grant_id;
                    we_d     = grant_id ? we1 : we0;
                    adrs_d   = grant_id ? adrs1 : adrs0;
                    wdata_d  = grant_id ? wdata1 : wdata0;
                    prio_d   = ~grant_id;
                    state_d  = StAcc;
                end
            end
            StAcc: begin
                mem_en  = 1'b1;
                mem_we  = we_q & legal;
                state_d = StResp;
            end
            StResp: begin
                done_d[id_q] = 1'b1;
                err_d[id_q]  = ~legal;
                if (!we_q) begin
                    if (id_q) begin
                        rdata1_d = legal ? mem_dout : '0;
                    end else begin
                        rdata0_d = legal ? mem_dout : '0;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            adrs_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            we_q     <= we_d;
            adrs_q   <= adrs_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign gnt0     = (state_q == StAcc || state_q == StResp) && !id_q;
    assign gnt1     = (state_q == StAcc || state_q == StResp) && id_q;
    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign err0     = err_q[0];
    assign err1     = err_q[1];
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_adrs = adrs_q;
    assign mem_din  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios plus a random run against a cycle model.
// Instance a uses all four words, instance b treats word 3 as out of range.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, we0, req1, we1;
    logic [1:0] adrs0, adrs1;
    logic [7:0] wdata0, wdata1;

    logic       gnt0, done0, err0, gnt1, done1, err1, mem_en, mem_we;
    logic [7:0] rdata0, rdata1, mem_din, mem_dout;
    logic [1:0] mem_adrs;
    logic       gnt0_b, done0_b, err0_b, gnt1_b, done1_b, err1_b, mem_en_b, mem_we_b;
    logic [7:0] rdata0_b, rdata1_b, mem_din_b, mem_dout_b;
    logic [1:0] mem_adrs_b;

    logic       pl_en = 1'b0;
    logic [1:0] pl_adrs = 2'd0;
    logic [7:0] pl_data = 8'd0;
    logic [7:0] ram_a [4];
    logic [7:0] ram_b [4];

    int errors = 0;
    int checks = 0;

    mem_arbiter_rr #(.ADRS_WIDTH(2), .WORD_DEPTH(4), .WORD_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .adrs0(adrs0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .adrs1(adrs1), .wdata1(wdata1),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0), .err0(err0),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1), .err1(err1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adrs(mem_adrs), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    mem_arbiter_rr #(.ADRS_WIDTH(2), .WORD_DEPTH(3), .WORD_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .adrs0(adrs0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .adrs1(adrs1), .wdata1(wdata1),
        .gnt0(gnt0_b), .done0(done0_b), .rdata0(rdata0_b), .err0(err0_b),
        .gnt1(gnt1_b), .done1(done1_b), .rdata1(rdata1_b), .err1(err1_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_adrs(mem_adrs_b), .mem_din(mem_din_b),
        .mem_dout(mem_dout_b)
    );

    // Synchronous-read memories with a backdoor preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            ram_a[pl_adrs] <= pl_data;
            ram_b[pl_adrs] <= pl_data;
        end
        if (mem_en) begin
            if (mem_we) ram_a[mem_adrs] <= mem_din;
            mem_dout <= ram_a[mem_adrs];
        end
        if (mem_en_b) begin
            if (mem_we_b) ram_b[mem_adrs_b] <= mem_din_b;
            mem_dout_b <= ram_b[mem_adrs_b];
        end
    end

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; adrs0 = 2'd0; wdata0 = 8'd0;
        req1 = 1'b0; we1 = 1'b0; adrs1 = 2'd0; wdata1 = 8'd0;
    endtask

    task automatic settle();
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_adrs = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic wait_done(input int port, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if ((port == 0 && done0) || (port == 1 && done1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [33:0] outs;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        outs = {gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we, mem_adrs, mem_din,
                rdata0, rdata1};
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs_a: got %h expected 0", outs);
        end
        outs = {gnt0_b, gnt1_b, done0_b, done1_b, err0_b, err1_b, mem_en_b, mem_we_b,
                mem_adrs_b, mem_din_b, rdata0_b, rdata1_b};
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs_b: got %h expected 0", outs);
        end

        preload(2'd2, 8'h11);
        req1 = 1'b1; we1 = 1'b1; adrs1 = 2'd2; wdata1 = 8'hA5;
        @(negedge clk);
        checks++;
        if ({gnt1, mem_en, mem_we} !== 3'b111 || mem_adrs !== 2'd2 || mem_din !== 8'hA5) begin
            errors++;
            $display("FAIL reset_acc_entry: got gnt1/en/we=%b adrs=%h din=%h expected 111 2 a5",
                     {gnt1, mem_en, mem_we}, mem_adrs, mem_din);
        end
        #1 rst = 1'b1;
        #1;
        outs = {gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we, mem_adrs, mem_din,
                rdata0, rdata1};
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid_acc: got %h expected 0", outs);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_a[2] !== 8'h11) begin
            errors++;
            $display("FAIL reset_no_write: got %h expected 11", ram_a[2]);
        end
    endtask

    task automatic test_single_read();
        int gcount = 0;
        int done_at = -1;
        logic [7:0] rd = 8'd0;
        logic [7:0] rd_b = 8'd0;
        logic er = 1'b1;
        preload(2'd1, 8'h3C);
        req0 = 1'b1; we0 = 1'b0; adrs0 = 2'd1; wdata0 = 8'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (gnt0) gcount++;
            if (done0 && done_at < 0) begin
                done_at = c; rd = rdata0; rd_b = rdata0_b; er = err0;
                req0 = 1'b0;
            end
        end
        checks++;
        if (gcount != 2) begin
            errors++;
            $display("FAIL read_gnt_cycles: got %0d expected 2", gcount);
        end
        checks++;
        if (done_at != 3) begin
            errors++;
            $display("FAIL read_done_latency: got %0d expected 3", done_at);
        end
        checks++;
        if (rd !== 8'h3C || er !== 1'b0 || rd_b !== 8'h3C) begin
            errors++;
            $display("FAIL read_data: got rdata0=%h err0=%b rdata0_b=%h expected 3c 0 3c",
                     rd, er, rd_b);
        end
    endtask

    task automatic test_contention();
        int ports[$];
        int times[$];
        logic pg0 = 1'b0;
        logic pg1 = 1'b0;
        int n;
        preload(2'd0, 8'h77);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; adrs0 = 2'd0;
        req1 = 1'b1; we1 = 1'b0; adrs1 = 2'd1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (gnt0 && !pg0) begin ports.push_back(0); times.push_back(c); end
            if (gnt1 && !pg1) begin ports.push_back(1); times.push_back(c); end
            pg0 = gnt0; pg1 = gnt1;
            if (done1 && c >= 12) req1 = 1'b0;
            if (done0 && c >= 13) req0 = 1'b0;
        end
        checks++;
        if (ports.size() != 5) begin
            errors++;
            $display("FAIL cont_grant_count: got %0d expected 5", ports.size());
        end
        n = (ports.size() < 5) ? ports.size() : 5;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ports[i] != i % 2 || times[i] != 1 + 3 * i) begin
                errors++;
                $display("FAIL cont_grant_%0d: got port %0d at %0d expected port %0d at %0d",
                         i, ports[i], times[i], i % 2, 1 + 3 * i);
            end
        end
        checks++;
        if (rdata0 !== 8'h77 || rdata1 !== 8'h3C) begin
            errors++;
            $display("FAIL cont_rdata: got %h %h expected 77 3c", rdata0, rdata1);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        settle();
        req1 = 1'b1; we1 = 1'b1; adrs1 = 2'd3; wdata1 = 8'hF0;
        wait_done(1, ok);
        checks++;
        if (!ok || err1 !== 1'b0 || rdata1 !== 8'h3C) begin
            errors++;
            $display("FAIL wr_port1: got done=%b err1=%b rdata1=%h expected 1 0 3c",
                     ok, err1, rdata1);
        end
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_a[3] !== 8'hF0) begin
            errors++;
            $display("FAIL wr_commit: got %h expected f0", ram_a[3]);
        end
        req0 = 1'b1; we0 = 1'b0; adrs0 = 2'd3;
        wait_done(0, ok);
        checks++;
        if (!ok || err0 !== 1'b0 || rdata0 !== 8'hF0) begin
            errors++;
            $display("FAIL rd_after_wr: got done=%b err0=%b rdata0=%h expected 1 0 f0",
                     ok, err0, rdata0);
        end
        req0 = 1'b0;
    endtask

    task automatic test_illegal();
        bit ok;
        logic saw_a = 1'b0;
        logic saw_b = 1'b0;
        logic found = 1'b0;
        settle();
        preload(2'd0, 8'h5A);
        req0 = 1'b1; we0 = 1'b0; adrs0 = 2'd0;
        wait_done(0, ok);
        checks++;
        if (!ok || rdata0_b !== 8'h5A || err0_b !== 1'b0) begin
            errors++;
            $display("FAIL ill_legal_read: got done=%b rdata0_b=%h err0_b=%b expected 1 5a 0",
                     ok, rdata0_b, err0_b);
        end
        settle();
        req0 = 1'b1; we0 = 1'b1; adrs0 = 2'd3; wdata0 = 8'h3C;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            saw_a |= mem_we;
            saw_b |= mem_we_b;
            if (done0) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || saw_b !== 1'b0 || err0_b !== 1'b1) begin
            errors++;
            $display("FAIL ill_write_b: got done=%b mem_we=%b err0_b=%b expected 1 0 1",
                     found, saw_b, err0_b);
        end
        checks++;
        if (saw_a !== 1'b1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL ill_write_a: got mem_we=%b err0=%b expected 1 0", saw_a, err0);
        end
        settle();
        req0 = 1'b1; we0 = 1'b0; adrs0 = 2'd3;
        wait_done(0, ok);
        checks++;
        if (!ok || rdata0_b !== 8'h00 || err0_b !== 1'b1) begin
            errors++;
            $display("FAIL ill_read_b: got done=%b rdata0_b=%h err0_b=%b expected 1 00 1",
                     ok, rdata0_b, err0_b);
        end
        checks++;
        if (rdata0 !== 8'h3C || err0 !== 1'b0) begin
            errors++;
            $display("FAIL ill_read_a: got rdata0=%h err0=%b expected 3c 0", rdata0, err0);
        end
        req0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rises[$];
        int dones[$];
        logic pg = 1'b0;
        settle();
        req0 = 1'b1; we0 = 1'b0; adrs0 = 2'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (gnt0 && !pg) rises.push_back(c);
            pg = gnt0;
            if (done0) begin
                dones.push_back(c);
                if (dones.size() == 2) req0 = 1'b0;
            end
        end
        checks++;
        if (rises.size() != 2 || rises[0] != 1 || rises[1] != 5) begin
            errors++;
            $display("FAIL b2b_grants: got %0d grants first %0d second %0d expected 2 1 5",
                     rises.size(), rises[0], rises[1]);
        end
        checks++;
        if (dones.size() != 2 || dones[0] != 3 || dones[1] != 7) begin
            errors++;
            $display("FAIL b2b_dones: got %0d pulses at %0d %0d expected 2 at 3 7",
                     dones.size(), dones[0], dones[1]);
        end
    endtask

    task automatic rand_fields(output logic w, output logic [1:0] a, output logic [7:0] d);
        w = 1'($urandom_range(1, 0));
        a = 2'($urandom_range(3, 0));
        d = 8'($urandom);
    endtask

    task automatic test_random();
        // Model: owner -1 when free, age 1 during the memory cycle, 2 during response.
        int m_owner = -1;
        int m_age = 0;
        int m_prio = 0;
        int pick;
        logic m_we = 1'b0;
        logic [1:0] m_adrs = 2'd0;
        logic [7:0] m_wdata = 8'd0;
        logic [7:0] m_rd_a = 8'd0;
        logic [7:0] m_rd_b = 8'd0;
        logic [1:0] m_done = 2'b00;
        logic [1:0] m_err_b = 2'b00;
        logic [1:0] nd;
        logic [7:0] m_rdata_a [2];
        logic [7:0] m_rdata_b [2];
        logic [7:0] gmem_a [4];
        logic [7:0] gmem_b [4];
        logic exp_we_a = 1'b0;
        logic exp_we_b = 1'b0;
        logic e0, e1;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gmem_a[i] = 8'($urandom);
            gmem_b[i] = gmem_a[i];
            preload(2'(i), gmem_a[i]);
        end
        for (int p = 0; p < 2; p++) begin m_rdata_a[p] = 8'd0; m_rdata_b[p] = 8'd0; end
        for (int cyc = 0; cyc < 300; cyc++) begin
            checks++;
            if ({gnt1, gnt0} !== {m_owner == 1, m_owner == 0}) begin
                errors++;
                $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, {gnt1, gnt0},
                         {m_owner == 1, m_owner == 0});
            end
            checks++;
            if ({done1, done0} !== m_done || {done1_b, done0_b} !== m_done) begin
                errors++;
                $display("FAIL rnd_done c%0d: got a=%b b=%b expected %b", cyc,
                         {done1, done0}, {done1_b, done0_b}, m_done);
            end
            checks++;
            if (mem_we !== exp_we_a || mem_we_b !== exp_we_b) begin
                errors++;
                $display("FAIL rnd_mem_we c%0d: got a=%b b=%b expected %b %b", cyc,
                         mem_we, mem_we_b, exp_we_a, exp_we_b);
            end
            checks++;
            if (rdata0 !== m_rdata_a[0] || rdata1 !== m_rdata_a[1] ||
                rdata0_b !== m_rdata_b[0] || rdata1_b !== m_rdata_b[1]) begin
                errors++;
                $display("FAIL rnd_rdata c%0d: got %h %h %h %h expected %h %h %h %h", cyc,
                         rdata0, rdata1, rdata0_b, rdata1_b,
                         m_rdata_a[0], m_rdata_a[1], m_rdata_b[0], m_rdata_b[1]);
            end
            if (m_done != 2'b00) begin
                checks++;
                if ((m_done & {err1, err0}) !== 2'b00 ||
                    (m_done & {err1_b, err0_b}) !== (m_done & m_err_b)) begin
                    errors++;
                    $display("FAIL rnd_err c%0d: got a=%b b=%b expected a=00 b=%b", cyc,
                             {err1, err0}, {err1_b, err0_b}, m_done & m_err_b);
                end
            end

            // Requesters hold until they see done, then drop or re-issue.
            if (req0) begin
                if (done0) begin
                    if ($urandom_range(1, 0) == 1) req0 = 1'b0;
                    else rand_fields(we0, adrs0, wdata0);
                end
            end else if ($urandom_range(9, 0) < 4) begin
                req0 = 1'b1;
                rand_fields(we0, adrs0, wdata0);
            end
            if (req1) begin
                if (done1) begin
                    if ($urandom_range(1, 0) == 1) req1 = 1'b0;
                    else rand_fields(we1, adrs1, wdata1);
                end
            end else if ($urandom_range(9, 0) < 4) begin
                req1 = 1'b1;
                rand_fields(we1, adrs1, wdata1);
            end

            e0 = req0 && !m_done[0];
            e1 = req1 && !m_done[1];
            nd = 2'b00;
            if (m_owner < 0) begin
                if (e0 || e1) begin
                    pick = (e0 && e1) ? m_prio : (e1 ? 1 : 0);
                    m_owner = pick;
                    m_age = 1;
                    m_we = (pick == 1) ? we1 : we0;
                    m_adrs = (pick == 1) ? adrs1 : adrs0;
                    m_wdata = (pick == 1) ? wdata1 : wdata0;
                    m_prio = 1 - pick;
                end
            end else if (m_age == 1) begin
                m_rd_a = gmem_a[m_adrs];
                m_rd_b = gmem_b[m_adrs];
                if (m_we) begin
                    gmem_a[m_adrs] = m_wdata;
                    if (m_adrs < 2'd3) gmem_b[m_adrs] = m_wdata;
                end
                m_age = 2;
            end else begin
                nd[m_owner] = 1'b1;
                m_err_b[m_owner] = (m_adrs >= 2'd3);
                if (!m_we) begin
                    m_rdata_a[m_owner] = m_rd_a;
                    m_rdata_b[m_owner] = (m_adrs < 2'd3) ? m_rd_b : 8'd0;
                end
                m_owner = -1;
                m_age = 0;
            end
            m_done = nd;
            exp_we_a = (m_owner >= 0) && (m_age == 1) && m_we;
            exp_we_b = exp_we_a && (m_adrs < 2'd3);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ram_a[i] !== gmem_a[i] || ram_b[i] !== gmem_b[i]) begin
                errors++;
                $display("FAIL rnd_final_mem_%0d: got %h %h expected %h %h", i,
                         ram_a[i], ram_b[i], gmem_a[i], gmem_b[i]);
            end
        end
        checks++;
        if (ram_a[3] !== gmem_a[3]) begin
            errors++;
            $display("FAIL rnd_final_mem_3: got %h expected %h", ram_a[3], gmem_a[3]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
